// File: rtl/input_pixel_unpacker_pkg.sv
// Shared pixel constants and FSM state type for the input pixel unpacker.
package input_pixel_unpacker_pkg;

  localparam int              CH_W     = 8;
  localparam int              CH_N     = 3;
  localparam logic [CH_W-1:0] RECENTRE = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Flipping the top bit maps uint8 0..255 onto int8 -128..127.
  function automatic logic [CH_W-1:0] recentre(input logic [CH_W-1:0] chByte,
                                               input logic            enable);
    return enable ? (chByte ^ RECENTRE) : chByte;
  endfunction

endpackage

// File: rtl/input_pixel_unpacker_skid_fifo2.sv
// Two-entry register FIFO. The head entry is always visible on head_o.
// count_o says how many entries hold data.
module pixel_skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic [1:0]       count_q, count_d;
  logic             doPush, doPop;

  assign doPush = push_i & (count_q != 2'd2);
  assign doPop  = pop_i & (count_q != 2'd0);

  // Entry 0 is the head; a pop shifts entry 1 forward, a push fills the first free slot.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    case ({doPush, doPop})
      2'b10: begin
        if (count_q == 2'd0) begin
          entry0_d = data_i;
        end else begin
          entry1_d = data_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        entry0_d = entry1_q;
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        entry0_d = data_i;
      end
      default: begin
      end
    endcase
  end

  // Storage registers; reset empties the buffer and zeroes the visible head.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = entry0_q;
  assign count_o = count_q;

endmodule

// File: rtl/input_pixel_unpacker.sv
// Pixel unpacker: pops 24-bit pixels from the input adapter, splits them into
// channels with optional int8 recentring, tags them with x/y and frame flags,
// and presents them on a valid/ready stream through a 2-entry buffer.
module input_pixel_unpacker
  import input_pixel_unpacker_pkg::*;
#(
  parameter int IMG_W     = 512,
  parameter int IMG_H     = 256,
  parameter int SIGNED_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [CH_N*CH_W-1:0]     i_data,
  input  logic                     i_empty,
  output logic                     o_fifo_rd_en,
  output logic [CH_W-1:0]          o_ch0,
  output logic [CH_W-1:0]          o_ch1,
  output logic [CH_W-1:0]          o_ch2,
  output logic [$clog2(IMG_W)-1:0] o_x,
  output logic [$clog2(IMG_H)-1:0] o_y,
  output logic                     o_sof,
  output logic                     o_eol,
  output logic                     o_eof,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int            XW      = $clog2(IMG_W);
  localparam int            YW      = $clog2(IMG_H);
  localparam int            EW      = CH_N*CH_W + XW + YW + 3;
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic          FLIP_EN = (SIGNED_EN != 0);

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    bufCount;
  logic [EW-1:0] pushEntry, headEntry;
  logic          rdEn, beatTaken, atSof, atEol, atEof, frameDone;

  assign rdEn      = (state_q == ST_RUN) & ~i_empty & (bufCount < 2'd2);
  assign beatTaken = o_valid & i_ready;
  assign atSof     = (x_q == '0) & (y_q == '0);
  assign atEol     = (x_q == X_LAST);
  assign atEof     = atEol & (y_q == Y_LAST);

  assign pushEntry = {recentre(i_data[2*CH_W +: CH_W], FLIP_EN),
                      recentre(i_data[CH_W +: CH_W], FLIP_EN),
                      recentre(i_data[0 +: CH_W], FLIP_EN),
                      x_q, y_q, atSof, atEol, atEof};

  // Frame sequencing: run until the last pixel is popped, then drain until the EOF beat leaves.
  always_comb begin
    state_d   = state_q;
    frameDone = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rdEn && atEof) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beatTaken && o_eof && (bufCount == 2'd1)) begin
          state_d   = ST_IDLE;
          frameDone = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Raster position of the next pixel to pop; cleared when a frame starts.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if ((state_q == ST_IDLE) && i_start) begin
      x_d = '0;
      y_d = '0;
    end else if (rdEn) begin
      if (atEof) begin
        x_d = '0;
        y_d = '0;
      end else if (atEol) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // State and position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  pixel_skid_fifo2 #(
    .WIDTH(EW)
  ) u_buffer (
    .clk    (clk),
    .rst    (rst),
    .push_i (rdEn),
    .pop_i  (beatTaken),
    .data_i (pushEntry),
    .head_o (headEntry),
    .count_o(bufCount)
  );

  assign {o_ch0, o_ch1, o_ch2, o_x, o_y, o_sof, o_eol, o_eof} = headEntry;

  assign o_fifo_rd_en = rdEn;
  assign o_valid      = (bufCount != 2'd0);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = frameDone;

endmodule

// File: tb/tb_input_pixel_unpacker.sv
// Self-checking bench for input_pixel_unpacker on a 4x2 frame with recentring enabled.
module tb_input_pixel_unpacker;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int XW = 2;
  localparam int YW = 1;
  localparam int VW = 3*8 + XW + YW + 4;

  logic          clk = 1'b0;
  logic          rst, i_start, i_empty, i_ready;
  logic [23:0]   i_data;
  logic          o_fifo_rd_en, o_sof, o_eol, o_eof, o_valid, o_busy, o_frame_done;
  logic [7:0]    o_ch0, o_ch1, o_ch2;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;

  int            checks = 0;
  int            errors = 0;
  logic [23:0]   src [N];
  int            srcIdx;

  input_pixel_unpacker #(
    .IMG_W(W),
    .IMG_H(H),
    .SIGNED_EN(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_data      (i_data),
    .i_empty     (i_empty),
    .o_fifo_rd_en(o_fifo_rd_en),
    .o_ch0       (o_ch0),
    .o_ch1       (o_ch1),
    .o_ch2       (o_ch2),
    .o_x         (o_x),
    .o_y         (o_y),
    .o_sof       (o_sof),
    .o_eol       (o_eol),
    .o_eof       (o_eof),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done)
  );

  // Free-running clock; posedges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Reference for the k-th accepted beat of a frame, straight from the raster rules.
  function automatic logic [VW-1:0] expBeat(input int k);
    logic [23:0]   p;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    p  = src[k];
    ex = XW'(k % W);
    ey = YW'(k / W);
    return {p[23:16] ^ 8'h80, p[15:8] ^ 8'h80, p[7:0] ^ 8'h80, ex, ey,
            (k == 0), ((k % W) == W - 1), (k == N - 1), (k == N - 1)};
  endfunction

  function automatic logic [VW-1:0] obsBeat();
    return {o_ch0, o_ch1, o_ch2, o_x, o_y, o_sof, o_eol, o_eof, o_frame_done};
  endfunction

  task automatic newFrameData();
    for (int i = 0; i < N; i++) src[i] = 24'($urandom);
    srcIdx = 0;
  endtask

  task automatic startFrame();
    @(negedge clk);
    i_start = 1'b1;
    i_empty = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    i_start = 1'b0;
    i_empty = 1'b0;
    i_ready = 1'b1;
    i_data  = 24'h123456;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({o_valid, o_fifo_rd_en, o_busy, o_frame_done} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_ctrl cycle %0d got %b want 0000", c,
                 {o_valid, o_fifo_rd_en, o_busy, o_frame_done});
      end
    end
    checks++;
    if ({o_ch0, o_ch1, o_ch2, o_x, o_y, o_sof, o_eol, o_eof} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h want 0", {o_ch0, o_ch1, o_ch2, o_x, o_y, o_sof, o_eol, o_eof});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int beat = 0, cyc = 0, firstCyc = -1, lastCyc = -1;
    logic [VW-1:0] ob, ex;
    newFrameData();
    src[0] = 24'h80FF00;
    startFrame();
    while (beat < N && cyc < 100) begin
      @(negedge clk);
      i_empty = 1'b0;
      i_ready = 1'b1;
      i_data  = src[srcIdx % N];
      #1;
      if (cyc == 0) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL basic_busy got %b want 1", o_busy);
        end
      end
      if (o_fifo_rd_en) srcIdx++;
      if (o_valid && i_ready) begin
        ob = obsBeat();
        ex = expBeat(beat);
        checks++;
        if (ob !== ex) begin
          errors++;
          $display("[TB] FAIL basic_beat%0d got %h want %h", beat, ob, ex);
        end
        if (beat == 0) begin
          firstCyc = cyc;
          checks++;
          if ({o_ch0, o_ch1, o_ch2, o_sof} !== {8'h00, 8'h7F, 8'h80, 1'b1}) begin
            errors++;
            $display("[TB] FAIL basic_first got %h want 007f801", {o_ch0, o_ch1, o_ch2, o_sof});
          end
        end
        lastCyc = cyc;
        beat++;
      end
      cyc++;
    end
    checks++;
    if (beat != N) begin
      errors++;
      $display("[TB] FAIL basic_timeout beats %0d want %0d", beat, N);
    end
    checks++;
    if (lastCyc - firstCyc != N - 1) begin
      errors++;
      $display("[TB] FAIL basic_throughput span %0d want %0d", lastCyc - firstCyc, N - 1);
    end
    checks++;
    if (srcIdx != N) begin
      errors++;
      $display("[TB] FAIL basic_pops got %0d want %0d", srcIdx, N);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({o_busy, o_valid, o_fifo_rd_en} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL basic_idle got %b want 000", {o_busy, o_valid, o_fifo_rd_en});
    end
  endtask

  task automatic test_stall();
    int beat = 0, cyc = 0, stallPops = 0;
    logic haveSnap = 1'b0;
    logic [VW-1:0] ob, ex, snap;
    newFrameData();
    startFrame();
    snap = '0;
    while (beat < N && cyc < 100) begin
      @(negedge clk);
      i_empty = (cyc >= 3 && cyc <= 5);
      i_ready = !(cyc >= 6 && cyc <= 10);
      i_data  = src[srcIdx % N];
      #1;
      ob = obsBeat();
      if (cyc >= 6 && cyc <= 10) begin
        if (o_fifo_rd_en) stallPops++;
        if (o_valid) begin
          if (!haveSnap) begin
            snap     = ob;
            haveSnap = 1'b1;
          end else begin
            checks++;
            if (ob !== snap) begin
              errors++;
              $display("[TB] FAIL stall_hold cycle %0d got %h want %h", cyc, ob, snap);
            end
          end
        end
      end
      if (o_fifo_rd_en) srcIdx++;
      if (o_valid && i_ready) begin
        ex = expBeat(beat);
        checks++;
        if (ob !== ex) begin
          errors++;
          $display("[TB] FAIL stall_beat%0d got %h want %h", beat, ob, ex);
        end
        beat++;
      end
      cyc++;
    end
    checks++;
    if (stallPops != 2) begin
      errors++;
      $display("[TB] FAIL stall_pops got %0d want 2", stallPops);
    end
    checks++;
    if (beat != N || srcIdx != N) begin
      errors++;
      $display("[TB] FAIL stall_count beats %0d pops %0d want %0d", beat, srcIdx, N);
    end
  endtask

  task automatic test_empty_toggle();
    int beat = 0, cyc = 0;
    logic [VW-1:0] ob, ex;
    newFrameData();
    startFrame();
    while (beat < N && cyc < 100) begin
      @(negedge clk);
      i_empty = (cyc % 2 == 0);
      i_ready = 1'b1;
      i_data  = src[srcIdx % N];
      #1;
      if (o_fifo_rd_en) srcIdx++;
      if (o_valid && i_ready) begin
        ob = obsBeat();
        ex = expBeat(beat);
        checks++;
        if (ob !== ex) begin
          errors++;
          $display("[TB] FAIL toggle_beat%0d got %h want %h", beat, ob, ex);
        end
        beat++;
      end
      cyc++;
    end
    checks++;
    if (beat != N || srcIdx != N) begin
      errors++;
      $display("[TB] FAIL toggle_count beats %0d pops %0d want %0d", beat, srcIdx, N);
    end
  endtask

  task automatic test_start_ignored();
    int beat = 0, cyc = 0;
    logic [VW-1:0] ob, ex;
    newFrameData();
    startFrame();
    while (beat < N && cyc < 100) begin
      @(negedge clk);
      i_start = (cyc == 3);
      i_empty = 1'b0;
      i_ready = 1'b1;
      i_data  = src[srcIdx % N];
      #1;
      if (o_fifo_rd_en) srcIdx++;
      if (o_valid && i_ready) begin
        ob = obsBeat();
        ex = expBeat(beat);
        checks++;
        if (ob !== ex) begin
          errors++;
          $display("[TB] FAIL restart_beat%0d got %h want %h", beat, ob, ex);
        end
        beat++;
      end
      cyc++;
    end
    i_start = 1'b0;
    checks++;
    if (beat != N || srcIdx != N) begin
      errors++;
      $display("[TB] FAIL restart_count beats %0d pops %0d want %0d", beat, srcIdx, N);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_idle busy %b want 0", o_busy);
    end
  endtask

  task automatic test_reset_midframe();
    int pops = 0;
    newFrameData();
    startFrame();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_empty = 1'b0;
      i_ready = (c < 2);
      i_data  = src[srcIdx % N];
      #1;
      if (o_fifo_rd_en) begin
        pops++;
        srcIdx++;
      end
    end
    checks++;
    if (pops != 3 || o_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_setup pops %0d valid %b want 3 1", pops, o_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_busy, o_fifo_rd_en} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midrst_state got %b want 000", {o_valid, o_busy, o_fifo_rd_en});
    end
  endtask

  task automatic test_random();
    int beat = 0, cyc = 0;
    logic [VW-1:0] ob, ex;
    newFrameData();
    startFrame();
    while (beat < N && cyc < 400) begin
      @(negedge clk);
      i_empty = ($urandom_range(0, 9) < 3);
      i_ready = ($urandom_range(0, 1) == 1);
      i_data  = src[srcIdx % N];
      #1;
      if (o_fifo_rd_en) srcIdx++;
      if (o_valid && i_ready) begin
        ob = obsBeat();
        ex = expBeat(beat);
        checks++;
        if (ob !== ex) begin
          errors++;
          $display("[TB] FAIL random_beat%0d got %h want %h", beat, ob, ex);
        end
        beat++;
      end
      cyc++;
    end
    checks++;
    if (beat != N || srcIdx != N) begin
      errors++;
      $display("[TB] FAIL random_count beats %0d pops %0d want %0d", beat, srcIdx, N);
    end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty_toggle();
    test_start_ignored();
    test_basic();
    test_reset_midframe();
    test_basic();
    for (int r = 0; r < 4; r++) test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
